seven_seg_scanner: RTL and testbench

- Parametrised N-digit multiplexed seven-segment driver: hex glyph decode, time-division scanning of common anodes, and a programmable blanking gap between digits to suppress ghosting.
- Runs from an externally supplied system clock; no oscillator is instantiated inside. Replaces the fixed two-digit multiplexer in the display path.
- Sits between switch/sum logic (digit sources) and the board segment/anode pins.

---
 rtl/seven_seg_scanner.sv | 169 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner: hex decode, anode time-division, inter-digit blanking.
// Define SEVEN_SEG_SCANNER_DIM_EN to add a 4-bit brightness PWM on the anodes.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned CLK_HZ         = 48000000,
  parameter int unsigned SCAN_HZ        = 250,
  parameter int unsigned BLANK_CYCLES   = 48,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
`ifdef SEVEN_SEG_SCANNER_DIM_EN
  input  logic [3:0]              brightness_i,
`endif
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_start_o
);

  localparam int unsigned Dwell =
      (SCAN_HZ * NUM_DIGITS == 0) ? 0 : CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int unsigned SlotW = (Dwell > 1) ? $clog2(Dwell) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(Dwell - 1);
  localparam logic [SlotW-1:0] BlankLim = SlotW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_digits
    $error("seven_seg_scanner: NUM_DIGITS must be in 1..8");
  end
  if (Dwell <= BLANK_CYCLES) begin : gen_bad_dwell
    $error("seven_seg_scanner: slot dwell must exceed BLANK_CYCLES");
  end

  typedef enum logic [0:0] {StBlank, StShow} state_e;

  // With no blanking, slot 0 is already a SHOW cycle.
  localparam state_e StateRst = (BLANK_CYCLES == 0) ? StShow : StBlank;

  state_e                state_q, state_d;
  logic [SlotW-1:0]      slot_q, slot_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [3:0]            snap_nib_q, snap_nib_d;
  logic                  snap_dp_q, snap_dp_d;
  logic                  snap_en_q, snap_en_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_on;
  logic                  an_gate;

`ifdef SEVEN_SEG_SCANNER_DIM_EN
  logic [3:0] pwm_q;

  always_ff @(posedge clk) begin
    if (reset) pwm_q <= 4'd0;
    else       pwm_q <= pwm_q + 4'd1;
  end

  assign an_gate = (pwm_q <= brightness_i);
`else
  assign an_gate = 1'b1;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  always_comb begin
    slot_d     = slot_q + SlotW'(1);
    idx_d      = idx_q;
    snap_nib_d = snap_nib_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    seg_on     = 7'h00;
    dp_on      = 1'b0;
    an_on      = '0;

    if (slot_q == SlotLast) begin
      slot_d = '0;
      idx_d  = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    state_d = (slot_d < BlankLim) ? StBlank : StShow;

    // The snapshot taken this cycle already feeds this cycle's output decode.
    if (slot_q == '0) begin
      snap_nib_d = digits_i[{idx_q, 2'b00} +: 4];
      snap_dp_d  = dp_i[idx_q];
      snap_en_d  = digit_en_i[idx_q];
    end

    unique case (state_q)
      StShow: begin
        if (snap_en_d) begin
          seg_on        = glyph(snap_nib_d);
          dp_on         = snap_dp_d;
          an_on[idx_q]  = an_gate;
        end
      end
      default: ;
    endcase

    seg_d = seg_on ^ {7{SEG_ACTIVE_LOW}};
    dp_d  = dp_on ^ SEG_ACTIVE_LOW;
    an_d  = an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    fs_d  = (slot_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StateRst;
      slot_q     <= '0;
      idx_q      <= '0;
      snap_nib_q <= 4'h0;
      snap_dp_q  <= 1'b0;
      snap_en_q  <= 1'b0;
      seg_q      <= {7{SEG_ACTIVE_LOW}};
      dp_q       <= SEG_ACTIVE_LOW;
      an_q       <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      snap_nib_q <= snap_nib_d;
      snap_dp_q  <= snap_dp_d;
      snap_en_q  <= snap_en_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign an_o          = an_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: 4 digits, dwell 8, blank 2, active-low outputs.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  en;
  logic [3:0]  bright = 4'hF;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;
  logic        fs;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS    (4),
    .CLK_HZ        (64),
    .SCAN_HZ       (2),
    .BLANK_CYCLES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .digits_i     (digits),
    .dp_i         (dp),
    .digit_en_i   (en),
`ifdef SEVEN_SEG_SCANNER_DIM_EN
    .brightness_i (bright),
`endif
    .seg_o        (seg),
    .dp_o         (dpo),
    .an_o         (an),
    .frame_start_o(fs)
  );

  typedef struct packed {
    logic       rst;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: t counts output cycles since reset release.
  int         t     = 0;
  int         pwm_m = 0;
  logic [3:0] m_nib [4];
  logic       m_dp  [4];
  logic       m_en  [4];

  task automatic step();
    exp_t e;
    int   slot;
    int   dig;
    e.rst = reset;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.an  = 4'hF;
    e.fs  = 1'b0;
    if (reset) begin
      t     = 0;
      pwm_m = 0;
    end else begin
      slot = t % 8;
      dig  = (t / 8) % 4;
      if (slot == 0) begin
        m_nib[dig] = digits[dig*4 +: 4];
        m_dp[dig]  = dp[dig];
        m_en[dig]  = en[dig];
      end
      if (slot >= 2 && m_en[dig]) begin
        e.seg = ~glyph_tab[m_nib[dig]];
        e.dp  = ~m_dp[dig];
        if (pwm_m <= int'(bright)) e.an = ~(4'b0001 << dig);
      end
      e.fs  = (t % 32 == 0);
      t++;
      pwm_m = (pwm_m + 1) % 16;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Steps until the output of cycle c (since release) is visible.
  task automatic run_until(input int c);
    while (t <= c) step();
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  int mcyc    = 0;
  int last_fs = -1;

  always @(negedge clk) begin
    exp_t e;
    mcyc++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if ({seg, dpo, an, fs} !== {e.seg, e.dp, e.an, e.fs}) begin
        bad++;
        $display("FAIL scoreboard cyc %0d: seg=%h dp=%b an=%b fs=%b want seg=%h dp=%b an=%b fs=%b",
                 mcyc, seg, dpo, an, fs, e.seg, e.dp, e.an, e.fs);
      end
      total++;
      if ($countones(~an) > 1) begin
        bad++;
        $display("FAIL anode_overlap cyc %0d: an=%b want at most one low", mcyc, an);
      end
      if (e.rst) begin
        last_fs = -1;
      end else if (fs) begin
        if (last_fs >= 0) begin
          total++;
          if (mcyc - last_fs != 32) begin
            bad++;
            $display("FAIL frame_period: got %0d want 32", mcyc - last_fs);
          end
        end
        last_fs = mcyc;
      end
    end
  end

  initial begin
    reset  = 1'b1;
    digits = 16'h12AF;
    dp     = 4'b0100;
    en     = 4'hF;
    repeat (3) step();
    chk("reset_an", {4'h0, an}, 8'h0F);
    chk("reset_seg", {1'b0, seg}, 8'h7F);
    chk("reset_dp", {7'h0, dpo}, 8'h01);
    chk("reset_fs", {7'h0, fs}, 8'h00);

    reset = 1'b0;
    run_until(0);
    chk("first_fs", {7'h0, fs}, 8'h01);
    chk("first_blank_an", {4'h0, an}, 8'h0F);
    run_until(2);
    chk("slot0_an", {4'h0, an}, 8'h0E);
    chk("slot0_seg", {1'b0, seg}, 8'h0E);
    run_until(7);
    chk("slot0_end_an", {4'h0, an}, 8'h0E);
    run_until(10);
    chk("slot1_seg", {1'b0, seg}, 8'h08);
    chk("slot1_an", {4'h0, an}, 8'h0D);
    run_until(18);
    chk("slot2_seg", {1'b0, seg}, 8'h24);
    chk("slot2_dp", {7'h0, dpo}, 8'h00);
    run_until(26);
    chk("slot3_seg", {1'b0, seg}, 8'h79);
    chk("slot3_an", {4'h0, an}, 8'h07);
    run_until(32);
    chk("frame2_fs", {7'h0, fs}, 8'h01);

    en = 4'b1011;
    run_until(50);
    chk("disabled_an", {4'h0, an}, 8'h0F);
    chk("disabled_seg", {1'b0, seg}, 8'h7F);
    run_until(58);
    chk("after_disabled_an", {4'h0, an}, 8'h07);

    en = 4'hF;
    run_until(68);
    digits = 16'h12A0;
    run_until(71);
    chk("snapshot_hold", {1'b0, seg}, 8'h0E);
    run_until(98);
    chk("snapshot_new", {1'b0, seg}, 8'h40);

    run_until(117);
    reset = 1'b1;
    step();
    chk("midshow_rst_an", {4'h0, an}, 8'h0F);
    chk("midshow_rst_seg", {1'b0, seg}, 8'h7F);
    chk("midshow_rst_fs", {7'h0, fs}, 8'h00);
    step();
    reset = 1'b0;
    run_until(0);
    chk("resume_fs", {7'h0, fs}, 8'h01);
    run_until(2);
    chk("resume_an", {4'h0, an}, 8'h0E);
    run_until(40);

`ifdef SEVEN_SEG_SCANNER_DIM_EN
    reset = 1'b1;
    step();
    reset  = 1'b0;
    bright = 4'h0;
    run_until(70);
    bright = 4'hF;
`endif

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
